// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar measurement blocks.
// Holds the 4-bit state codes exposed on db_estado and the default
// echo-timeout settings (30 ms at 50 MHz).
package sonar_pkg;

  localparam int DEFAULT_TIMEOUT = 1500000;
  localparam int DEFAULT_TW      = 21;

  localparam logic [3:0] ST_INICIAL      = 4'h0;
  localparam logic [3:0] ST_PREPARACAO   = 4'h1;
  localparam logic [3:0] ST_ESPERA_PULSO = 4'h2;
  localparam logic [3:0] ST_CONTAGEM     = 4'h3;
  localparam logic [3:0] ST_FIM_MEDIDA   = 4'h4;
  localparam logic [3:0] ST_ERRO         = 4'hF;

  // True in the two states where the echo timeout is running.
  function automatic logic is_waiting(input logic [3:0] st);
    return (st == ST_ESPERA_PULSO) || (st == ST_CONTAGEM);
  endfunction

endpackage

// File: rtl/contador_m.sv
// Generic modulo-M up counter.
// Ports:
//   clock   - rising-edge clock
//   zera_as - asynchronous clear, active high
//   zera_s  - synchronous clear, has priority over conta
//   conta   - count enable
//   fim     - high while the count equals M-1
module contador_m #(
  parameter int M = 16,
  parameter int N = 4
) (
  input  logic clock,
  input  logic zera_as,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  logic [N-1:0] count_r;

  // Count register: async clear, then sync clear, then wrap-around count.
  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      count_r <= {N{1'b0}};
    end else if (zera_s) begin
      count_r <= {N{1'b0}};
    end else if (conta) begin
      if (count_r == N'(M - 1)) begin
        count_r <= {N{1'b0}};
      end else begin
        count_r <= count_r + N'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

  // Terminal-count flag.
  always_comb begin
    fim = 1'b0;
    if (count_r == N'(M - 1)) begin
      fim = 1'b1;
    end else begin
      fim = 1'b0;
    end
  end

endmodule

// File: rtl/contador_cm_uc.sv
// Control unit for the centimetre-counting datapath.
// On medir it clears the tick/BCD counters, waits for the echo, enables
// the tick counter while the echo is high and forwards each tick as a BCD
// increment. Ends with a one-cycle pronto, or erro on timeout/overflow.
// Ports:
//   clock, reset (async, active low)
//   medir  - start request (accepted in inicial/erro only)
//   pulso  - synchronised echo
//   tick   - datapath mid-period tick
//   fim    - BCD counter at 999
//   zera_tick/conta_tick/zera_bcd/conta_bcd - datapath controls
//   pronto - one-cycle done pulse
//   erro   - held while in the error state
//   db_estado - current state code
module contador_cm_uc
  import sonar_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TW      = DEFAULT_TW
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       medir,
  input  logic       pulso,
  input  logic       tick,
  input  logic       fim,
  output logic       zera_tick,
  output logic       conta_tick,
  output logic       zera_bcd,
  output logic       conta_bcd,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);

  logic [3:0] state_r;
  logic [3:0] next_state_s;
  logic       timeout_s;
  logic       clear_as_s;
  logic       clear_timeout_s;
  logic       run_timeout_s;

  // Timeout counter holds at its terminal value instead of wrapping, so a
  // late pulso rise cannot earn a second timeout window.
  assign clear_as_s      = ~reset;
  assign clear_timeout_s = (state_r == ST_PREPARACAO);
  assign run_timeout_s   = is_waiting(state_r) & ~timeout_s;

  contador_m #(
    .M (TIMEOUT),
    .N (TW)
  ) u_timeout (
    .clock   (clock),
    .zera_as (clear_as_s),
    .zera_s  (clear_timeout_s),
    .conta   (run_timeout_s),
    .fim     (timeout_s)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_INICIAL;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; unknown codes fall back to inicial.
  always_comb begin
    next_state_s = ST_INICIAL;
    case (state_r)
      ST_INICIAL: begin
        if (medir) begin
          next_state_s = ST_PREPARACAO;
        end else begin
          next_state_s = ST_INICIAL;
        end
      end
      ST_PREPARACAO: begin
        next_state_s = ST_ESPERA_PULSO;
      end
      ST_ESPERA_PULSO: begin
        if (pulso) begin
          next_state_s = ST_CONTAGEM;
        end else if (timeout_s) begin
          next_state_s = ST_ERRO;
        end else begin
          next_state_s = ST_ESPERA_PULSO;
        end
      end
      ST_CONTAGEM: begin
        // Echo fall wins over overflow and timeout.
        if (!pulso) begin
          next_state_s = ST_FIM_MEDIDA;
        end else if (tick && fim) begin
          next_state_s = ST_ERRO;
        end else if (timeout_s) begin
          next_state_s = ST_ERRO;
        end else begin
          next_state_s = ST_CONTAGEM;
        end
      end
      ST_FIM_MEDIDA: begin
        next_state_s = ST_INICIAL;
      end
      ST_ERRO: begin
        if (medir) begin
          next_state_s = ST_PREPARACAO;
        end else begin
          next_state_s = ST_ERRO;
        end
      end
      default: begin
        next_state_s = ST_INICIAL;
      end
    endcase
  end

  // Output decode: Moore on state, except conta_bcd which also looks at
  // tick/pulso/fim so a tick on the echo fall or at 999 is not counted.
  always_comb begin
    zera_tick  = 1'b0;
    conta_tick = 1'b0;
    zera_bcd   = 1'b0;
    conta_bcd  = 1'b0;
    pronto     = 1'b0;
    erro       = 1'b0;
    db_estado  = state_r;
    case (state_r)
      ST_PREPARACAO: begin
        zera_tick = 1'b1;
        zera_bcd  = 1'b1;
      end
      ST_CONTAGEM: begin
        conta_tick = 1'b1;
        conta_bcd  = tick & pulso & ~fim;
      end
      ST_FIM_MEDIDA: begin
        pronto = 1'b1;
      end
      ST_ERRO: begin
        erro = 1'b1;
      end
      default: begin
        zera_tick = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_contador_cm_uc.sv
module tb_contador_cm_uc;

  localparam int TO = 64;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       medir = 1'b0;
  logic       pulso = 1'b0;
  logic       fim   = 1'b0;
  logic       tick;
  logic       zera_tick, conta_tick, zera_bcd, conta_bcd, pronto, erro;
  logic [3:0] db_estado;

  int n_checks = 0;
  int n_fail   = 0;

  // Datapath stand-in: mod-4 tick counter, tick at count 2.
  bit         use_dp    = 1'b1;
  logic       tick_rand = 1'b0;
  logic [1:0] dp_cnt    = 2'd0;
  assign tick = use_dp ? (dp_cnt == 2'd2) : tick_rand;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (zera_tick) dp_cnt <= 2'd0;
    else if (conta_tick) dp_cnt <= dp_cnt + 2'd1;
  end

  contador_cm_uc #(.TIMEOUT(TO), .TW(6)) dut (
    .clock      (clock),
    .reset      (reset),
    .medir      (medir),
    .pulso      (pulso),
    .tick       (tick),
    .fim        (fim),
    .zera_tick  (zera_tick),
    .conta_tick (conta_tick),
    .zera_bcd   (zera_bcd),
    .conta_bcd  (conta_bcd),
    .pronto     (pronto),
    .erro       (erro),
    .db_estado  (db_estado)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: measurement phases plus elapsed waiting time.
  typedef enum {M_IDLE, M_PREP, M_WAIT, M_COUNT, M_DONE, M_ERR} mphase_t;
  mphase_t mph     = M_IDLE;
  int      elapsed = 0;

  function automatic int code_of(input mphase_t p);
    case (p)
      M_IDLE:  return 0;
      M_PREP:  return 1;
      M_WAIT:  return 2;
      M_COUNT: return 3;
      M_DONE:  return 4;
      default: return 15;
    endcase
  endfunction

  // Per-cycle comparison against the model; inputs are stable from the
  // previous posedge+1 through the next posedge, so they are used here.
  always @(negedge clock) begin
    logic [9:0] exp_v;
    logic [9:0] act_v;
    bit         timed_out;
    act_v = {db_estado, zera_tick, conta_tick, zera_bcd, conta_bcd, pronto, erro};
    if (!reset) begin
      mph = M_IDLE;
      elapsed = 0;
      check("reset_outputs", act_v, 0);
    end else begin
      exp_v = {4'(code_of(mph)), mph == M_PREP, mph == M_COUNT, mph == M_PREP,
               (mph == M_COUNT) && tick && pulso && !fim, mph == M_DONE, mph == M_ERR};
      check("model_outputs", act_v, exp_v);
      timed_out = (elapsed >= TO - 1);
      case (mph)
        M_IDLE:  if (medir) mph = M_PREP;
        M_PREP:  begin elapsed = 0; mph = M_WAIT; end
        M_WAIT: begin
          if (pulso) mph = M_COUNT;
          else if (timed_out) mph = M_ERR;
          elapsed++;
        end
        M_COUNT: begin
          if (!pulso) mph = M_DONE;
          else if (tick && fim) mph = M_ERR;
          else if (timed_out) mph = M_ERR;
          elapsed++;
        end
        M_DONE:  mph = M_IDLE;
        default: if (medir) mph = M_PREP;
      endcase
    end
  end

  typedef struct {
    int w;          // cycles of low echo after entering espera_pulso
    int len;        // echo high length in clocks
    bit fim_on;     // BCD counter reports 999 throughout
    int medir_at;   // cycle index of a stray medir (-1 none)
    int exp_bcd;    // expected conta_bcd pulses
    int exp_pronto; // expected pronto pulses
    bit exp_erro;   // ends in erro
    int exp_end;    // cycle index where inicial/erro is first seen
  } row_t;

  row_t rows[9];

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic run_row(input row_t r, input int idx);
    int bcd;
    int npr;
    int end_i;
    bit done;
    bcd = 0; npr = 0; end_i = -1; done = 1'b0;
    pulso = 1'b0; fim = 1'b0; medir = 1'b1;
    cyc();
    medir = 1'b0;
    @(negedge clock);
    check($sformatf("row%0d_prep_state", idx), db_estado, 1);
    check($sformatf("row%0d_zera", idx), {zera_tick, zera_bcd}, 3);
    cyc();
    for (int i = 0; i < 400 && !done; i++) begin
      pulso = (i >= r.w) && (i < r.w + r.len);
      fim   = r.fim_on;
      medir = (i == r.medir_at);
      @(negedge clock);
      if (i == 0) check($sformatf("row%0d_wait_state", idx), db_estado, 2);
      bcd += int'(conta_bcd);
      npr += int'(pronto);
      if (db_estado == 4'h0 || db_estado == 4'hF) begin
        end_i = i;
        done = 1'b1;
      end
      cyc();
    end
    medir = 1'b0;
    check($sformatf("row%0d_budget", idx), done, 1);
    check($sformatf("row%0d_bcd_count", idx), bcd, r.exp_bcd);
    check($sformatf("row%0d_pronto_count", idx), npr, r.exp_pronto);
    check($sformatf("row%0d_erro", idx), erro, r.exp_erro);
    check($sformatf("row%0d_end_cycle", idx), end_i, r.exp_end);
  endtask

  initial begin
    rows[0] = '{0, 20, 1'b0, -1, 5, 1, 1'b0, 22};
    rows[1] = '{3, 4, 1'b0, -1, 1, 1, 1'b0, 9};
    rows[2] = '{0, 20, 1'b0, 8, 5, 1, 1'b0, 22};
    rows[3] = '{10, 30, 1'b0, -1, 7, 1, 1'b0, 42};
    rows[4] = '{0, 63, 1'b0, -1, 15, 1, 1'b0, 65};
    rows[5] = '{0, 64, 1'b0, -1, 16, 0, 1'b1, 64};
    rows[6] = '{64, 0, 1'b0, -1, 0, 0, 1'b1, 64};
    rows[7] = '{0, 20, 1'b1, -1, 0, 0, 1'b1, 4};
    rows[8] = '{0, 6, 1'b0, -1, 1, 1, 1'b0, 8};

    // Reset state.
    repeat (2) @(negedge clock);
    check("reset_db_estado", db_estado, 0);
    check("reset_erro", erro, 0);
    cyc();
    reset = 1'b1;

    for (int k = 0; k < 9; k++) run_row(rows[k], k);

    // Asynchronous reset in the middle of contagem.
    medir = 1'b1;
    cyc();
    medir = 1'b0;
    cyc();
    pulso = 1'b1;
    repeat (4) cyc();
    check("pre_reset_conta_tick", conta_tick, 1);
    check("pre_reset_db", db_estado, 3);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_conta_tick", conta_tick, 0);
    check("async_reset_db", db_estado, 0);
    check("async_reset_outputs",
          {zera_tick, zera_bcd, conta_bcd, pronto, erro}, 0);
    cyc();
    reset = 1'b1;
    pulso = 1'b0;
    cyc();
    @(negedge clock);
    check("post_reset_db", db_estado, 0);
    cyc();

    // Randomised traffic checked by the per-cycle model.
    use_dp = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      medir     = ($urandom_range(0, 7) == 0);
      tick_rand = ($urandom_range(0, 3) == 0);
      fim       = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 39) == 0) pulso = ~pulso;
      reset     = ($urandom_range(0, 399) != 0);
      cyc();
    end
    reset = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
